// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Bit-counter width: clog2 of the word width, never narrower than one bit.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: sync load-to-zero, increment enable,
// terminal flag at WIDTH-1 (holds there until reloaded).
import piso_pkg::*;

module piso_bit_counter #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          load_zero,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign terminal = (count == LAST);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load_zero) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word load, one bit per clock
// on ser_out with ser_valid, zero-gap reload on the last bit of a word.
import piso_pkg::*;

module piso_serializer #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             terminal;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    assign load_ready = (state == IDLE) || ((state == SHIFT) && terminal);
    assign accept     = load_valid && load_ready;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_counter (
        .clock     (clock),
        .clear     (clear),
        .load_zero (accept),
        .enable    (state == SHIFT),
        .count     (count),
        .terminal  (terminal)
    );

    // shreg holds the word aligned so its head bit is the one currently on
    // ser_out; the output register is fed one position ahead of the shift.
    always_comb begin
        first_bit = '0;
        next_bit  = '0;
        shifted   = '0;
        if (MSB_FIRST) begin
            first_bit = load_data[WIDTH-1];
            next_bit  = shreg[WIDTH-2];
            shifted   = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            first_bit = load_data[0];
            next_bit  = shreg[1];
            shifted   = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            shreg     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            shreg     <= load_data;
            ser_out   <= first_bit;
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (terminal) begin
                        state     <= IDLE;
                        shreg     <= '0;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        shreg   <= shifted;
                        ser_out <= next_bit;
                        done    <= (count == PENULT);
                    end
                end
                default: begin
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream;
// accepted words push per-cycle expectations, a negedge monitor pops and compares.
module tb_piso_serializer;

    logic       clock = 1'b0;
    logic       clear;
    logic [3:0] load_data;
    logic       load_valid;

    logic ready_m, out_m, valid_m, busy_m, done_m;
    logic ready_l, out_l, valid_l, busy_l, done_l;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clock      (clock),
        .clear      (clear),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .ser_out    (out_m),
        .ser_valid  (valid_m),
        .busy       (busy_m),
        .done       (done_m)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clock      (clock),
        .clear      (clear),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .ser_out    (out_l),
        .ser_valid  (valid_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Downstream 4-stage serial-in shift register; chain[3] is the output stage.
    logic [3:0] chain = '0;
    always @(posedge clock) if (valid_m) chain <= {chain[2:0], out_m};

    typedef struct {
        int   cyc;
        logic bm;
        logic bl;
        logic last;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Present a word and hold load_valid until the edge that accepts it.
    task automatic send(input logic [3:0] w);
        int waited = 0;
        load_data  = w;
        load_valid = 1'b1;
        while (!ready_m && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!ready_m) begin
            timeout_fail("send_ready");
            load_valid = 1'b0;
        end else begin
            @(posedge clock); #1;
            for (int i = 0; i < 4; i++)
                sbq.push_back('{cyc + i, w[3-i], w[i], (i == 3)});
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sbq.size() > 0 && waited < 40) begin
            @(posedge clock); #1;
            waited++;
        end
        if (sbq.size() > 0) begin
            timeout_fail("drain");
            sbq.delete();
        end
    endtask

    always @(negedge clock) begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            check("valid_m", valid_m, 1);
            check("valid_l", valid_l, 1);
            check("out_m", out_m, e.bm);
            check("out_l", out_l, e.bl);
            check("done_m", done_m, e.last);
            check("done_l", done_l, e.last);
            check("ready_m", ready_m, e.last);
            check("ready_l", ready_l, e.last);
            check("busy_m", busy_m, 1);
            check("busy_l", busy_l, 1);
        end else begin
            check("idle_valid_m", valid_m, 0);
            check("idle_valid_l", valid_l, 0);
            check("idle_done_m", done_m, 0);
            check("idle_done_l", done_l, 0);
            check("idle_busy_m", busy_m, 0);
            check("idle_ready_m", ready_m, 1);
            check("idle_ready_l", ready_l, 1);
        end
    end

    initial begin
        clear      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_m", out_m, 0);
        check("rst_valid_m", valid_m, 0);
        check("rst_busy_m", busy_m, 0);
        check("rst_done_m", done_m, 0);
        check("rst_ready_m", ready_m, 1);
        clear = 1'b0;
        @(posedge clock); #1;

        // Single word: MSB 1,0,1,1 and LSB 1,1,0,1.
        send(4'b1011);
        load_valid = 1'b0;
        drain();
        repeat (2) @(posedge clock); #1;

        // Back-to-back with load_valid held high.
        send(4'hA);
        send(4'h5);
        load_valid = 1'b0;
        drain();
        repeat (2) @(posedge clock); #1;

        // Backpressure: offers during count 0 and 1 must be ignored.
        send(4'b0110);
        load_data = 4'hF;
        check("bp_ready_c0", ready_m, 0);
        @(posedge clock); #1;
        load_valid = 1'b0;
        check("bp_ready_c1", ready_m, 0);
        load_data = 4'h0;
        @(posedge clock); #1;
        send(4'hF);
        load_valid = 1'b0;
        drain();
        repeat (2) @(posedge clock); #1;

        // End-to-end into the serial-in shift register.
        send(4'b1001);
        load_valid = 1'b0;
        drain();
        check("chain_word", chain, 4'b1001);
        repeat (2) @(posedge clock); #1;

        // Reset mid-word after two bits: outputs clear at once, no done later.
        send(4'b1011);
        load_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #2;
        clear = 1'b1;
        sbq.delete();
        #1;
        check("mid_rst_out_m", out_m, 0);
        check("mid_rst_valid_m", valid_m, 0);
        check("mid_rst_busy_m", busy_m, 0);
        check("mid_rst_done_m", done_m, 0);
        check("mid_rst_valid_l", valid_l, 0);
        check("mid_rst_done_l", done_l, 0);
        @(posedge clock); #1;
        clear = 1'b0;
        check("post_rst_ready_m", ready_m, 1);
        check("post_rst_ready_l", ready_l, 1);
        repeat (6) @(posedge clock); #1;

        // Recovery after reset.
        send(4'b0011);
        load_valid = 1'b0;
        drain();
        repeat (2) @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the driving end of the serial shift chain used by the team's serial-in shift register.
- Accepts a WIDTH-bit word via a valid/ready handshake and emits it one bit per clock on ser_out, with a qualifying ser_valid strobe.
- Supports back-to-back words with zero idle cycles, so a downstream shift register receives a continuous bit stream.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- clear  input  1  reset, asynchronous and active-high; forces all state and outputs to reset values immediately.
- load_data  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  serializer can accept a word this cycle (combinational from state/count).
- ser_out  output  1  registered serial data bit.
- ser_valid  output  1  registered; ser_out carries a valid bit this cycle.
- busy  output  1  registered; a word is in flight (state SHIFT).
- done  output  1  registered one-cycle pulse, high on the cycle the last bit of a word is on ser_out.

Behaviour:
- Reset (clear=1, any time, asynchronous): state=IDLE, shift register=0, bit count=0, ser_out=0, ser_valid=0, busy=0, done=0. A word in flight is abandoned with no partial completion and no done pulse.
- Accept condition: load_valid && load_ready on a rising edge of clock.
- load_ready = (state==IDLE) || (state==SHIFT && count==WIDTH-1). It does not depend on load_valid.
- IDLE:
  - ser_valid=0, ser_out=0, busy=0.
  - On accept: capture load_data, go to SHIFT, count=0.
  - The first bit appears on ser_out in the cycle after the accept edge, so latency is 1 cycle.
- SHIFT:
  - Each cycle ser_out = current bit, ser_valid=1, busy=1.
  - The shift register moves one position per clock: left for MSB_FIRST=1, right for MSB_FIRST=0.
  - count increments by 1 per cycle, from 0 to WIDTH-1.
  - done=1 exactly in the cycle count==WIDTH-1.
- End of word (edge leaving count==WIDTH-1):
  - If an accept occurs on that edge: reload the new word, count=0, stay in SHIFT. The next word's first bit follows the previous word's last bit in the immediately next cycle, with no gap.
  - Otherwise: go to IDLE. ser_valid and busy drop to 0 in the next cycle.
- Each word occupies exactly WIDTH consecutive ser_valid cycles.
- load_data changes while in SHIFT (not accepted) have no effect on the word in flight.
- count width: clog2(WIDTH), minimum 1 bit. count never exceeds WIDTH-1; wrap to 0 happens only on reload.
- Chain compatibility: with MSB_FIRST=1, a 4-stage serial-in shift register clocked WIDTH times on ser_valid cycles holds the word with the first-sent bit at its output stage.

Decomposition:
- Shared package piso_pkg:
  - state enum {IDLE, SHIFT}
  - count-width constant function (clog2, minimum 1)
  - default WIDTH constant
- One sub-module: piso_bit_counter.
  - Synchronous load-to-zero, increment enable, terminal-count flag at WIDTH-1.
  - Same clock and clear.
- The top level holds the FSM, the data shift register and the output registers.

Test Plan:
- Reset mid-word: WIDTH=4, load 4'b1011, assert clear after 2 bits -> ser_out=0, ser_valid=0, busy=0, done=0 immediately; load_ready=1 after clear deasserts; no done pulse ever appears for that word.
- Single word, MSB_FIRST=1: load 4'b1011 in IDLE -> starting next cycle, ser_out = 1,0,1,1 with ser_valid=1 for exactly 4 cycles; done high only on the 4th bit; busy=0 afterwards.
- LSB first: MSB_FIRST=0, load 4'b1011 -> ser_out = 1,1,0,1; done on the 4th bit.
- Back-to-back: load_valid held high with 4'hA then 4'h5 -> 8 contiguous ser_valid cycles carrying 1,0,1,0,0,1,0,1; load_ready=1 only in IDLE and on done cycles; two done pulses 4 cycles apart.
- Backpressure: pulse load_valid with 4'hF during SHIFT when count<3 -> not accepted, load_ready=0, in-flight bits unchanged; word is accepted only when load_ready=1.
- End-to-end: drive the 4-stage serial-in shift register with ser_out, clocked on ser_valid cycles; after word 4'b1001 -> its 4 stages hold 1,0,0,1 from output stage to input stage.
